apb4_mem_slave: RTL and testbench

//  Parametrised APB4 memory-mapped slave; successor to the fixed 8-bit-address/16-bit-data slave.
//  - Adds byte strobes, configurable wait states, PSLVERR decode and protocol-violation detection.
//  - Sits behind the APB bridge as a scratch/config RAM. One slave per PSEL line.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_bram_be.sv | 53 +++++
 rtl/apb4_mem_slave.sv | 166 ++++++++++++++++
 tb/tb_apb4_mem_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for APB slaves.
//   apb_st_e       : slave transfer FSM states (IDLE, WAIT, READY).
//   PSLVERR_*      : PSLVERR encodings.
//   strb_w/lsb_of  : derive the byte-strobe width (STRB_W) and the word-address
//                    LSB (LSB) from a data width. These are functions because each
//                    slave instance has its own DATA_W parameter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_st_e;

    localparam logic PSLVERR_OKAY  = 1'b0;
    localparam logic PSLVERR_ERROR = 1'b1;

    // STRB_W = DATA_W/8
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // LSB = log2(STRB_W): the first paddr bit that selects a word
    function automatic int lsb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_bram_be.sv
// Single-port DEPTH x DATA_W RAM with per-byte write enables and a registered read port.
// Ports:
//   clk_i    : clock, rising edge.
//   rst_i    : asynchronous active-high reset; clears only the read register, not the array.
//   addr_i   : word address shared by read and write (one access per cycle).
//   we_i     : write enable; bytes with be_i[b]=1 are written.
//   be_i     : byte enables.
//   wdata_i  : write data.
//   re_i     : read enable; loads rdata_o from the array at addr_i.
//   rclr_i   : loads rdata_o with zero (used for errored reads); wins over re_i.
//   rdata_o  : registered read data, held until the next re_i/rclr_i.
module apb_bram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     addr_i,
    input  logic              we_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rclr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave: scratch/config RAM with byte strobes, configurable wait
// states, PSLVERR decode and a sticky protocol-violation flag.
// Ports:
//   pclk, rst          : clock (rising edge) and asynchronous active-high reset.
//   psel, penable      : APB select and access-phase indicator.
//   pwrite             : 1 = write, 0 = read.
//   paddr, pwdata      : byte address and write data, captured in the setup cycle.
//   pstrb              : write byte strobes (ignored on reads).
//   prdata             : registered read data, held until the next read.
//   pready             : registered transfer-complete.
//   pslverr            : transfer error, only ever high together with pready.
//   proto_err          : sticky protocol-violation flag, cleared only by rst.
//   dbg_state_o        : current FSM state for observation.
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) taken in IDLE,
// followed by access cycles (psel=1, penable=1) until pready=1; the transfer completes
// at the rising edge that ends the pready=1 cycle. Dropping psel or penable before that
// edge is a protocol violation: the transfer is abandoned without a write.
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  proto_err,
    output apb_st_e               dbg_state_o
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int LSB    = lsb_of(DATA_W);
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int CNT_W  = 4;

    apb_st_e             state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pready_q;
    logic                pslverr_q;
    logic                proto_err_q;
    logic [RAM_AW-1:0]   idx_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                err_q;

    // Setup-cycle decode, taken from the live bus.
    logic                setup_d;
    logic [ADDR_W-1:0]   idx_d;
    logic                misalign_d;
    logic                range_err_d;
    logic                err_d;

    assign setup_d     = (state_q == IDLE) && psel && !penable;
    assign idx_d       = paddr >> LSB;
    // Mask form avoids a zero-width slice when DATA_W == 8.
    assign misalign_d  = (paddr & ADDR_W'(STRB_W - 1)) != '0;
    assign range_err_d = {1'b0, idx_d} >= (ADDR_W + 1)'(DEPTH);
    assign err_d       = misalign_d || range_err_d;

    // RAM control. The read happens on the setup edge from the live address so prdata
    // is valid by the first possible READY cycle; the write happens on the edge that
    // ends READY from the latched address. Only one of the two can be active.
    logic              ram_we;
    logic              ram_re;
    logic              ram_rclr;
    logic [RAM_AW-1:0] ram_addr;

    assign ram_we   = (state_q == READY) && psel && penable && write_q && !err_q;
    assign ram_re   = setup_d && !pwrite && !err_d;
    assign ram_rclr = setup_d && !pwrite && err_d;
    assign ram_addr = (state_q == IDLE) ? idx_d[RAM_AW-1:0] : idx_q;

    apb_bram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW),
        .STRB_W (STRB_W)
    ) u_ram (
        .clk_i   (pclk),
        .rst_i   (rst),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (strb_q),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .rclr_i  (ram_rclr),
        .rdata_o (prdata)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= PSLVERR_OKAY;
            proto_err_q <= 1'b0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup_d) begin
                        idx_q   <= idx_d[RAM_AW-1:0];
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        err_q   <= err_d;
                        if (WAIT_STATES == 0) begin
                            state_q   <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_d ? PSLVERR_ERROR : PSLVERR_OKAY;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (psel && penable) begin
                        if (cnt_q == '0) begin
                            state_q   <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q ? PSLVERR_ERROR : PSLVERR_OKAY;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end else begin
                        proto_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                READY: begin
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= PSLVERR_OKAY;
                    if (!(psel && penable)) begin
                        proto_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign proto_err   = proto_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave. Three instances share the bus (except psel) with
// WAIT_STATES = 0, 3 and 2.
module tb_apb4_mem_slave;
    import apb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;

    // clock / reset
    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    logic           penable, pwrite;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [3:0]     pstrb;
    logic           psel      [3];
    logic [DW-1:0]  prdata    [3];
    logic           pready    [3];
    logic           pslverr   [3];
    logic           proto_err [3];
    apb_st_e        st        [3];

    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .rst(rst), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .proto_err(proto_err[0]),
        .dbg_state_o(st[0]));
    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .pclk(pclk), .rst(rst), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .proto_err(proto_err[1]),
        .dbg_state_o(st[1]));
    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .pclk(pclk), .rst(rst), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]), .proto_err(proto_err[2]),
        .dbg_state_o(st[2]));

    // scoreboard: {is_read, exp_err, exp_rdata}
    logic [33:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: one complete transfer on instance k
    task automatic xfer(input int k, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] strb,
                        input logic exp_err, input logic [DW-1:0] exp_rdata,
                        input int exp_waits, input string name);
        int waits;
        logic got;
        logic [33:0] e;
        exp_q.push_back({~wr, exp_err, exp_rdata});
        @(posedge pclk); #1;
        psel[k] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        // the slave must use the values captured at setup
        paddr  = AW'($urandom_range(0, 4095));
        pwdata = $urandom;
        waits = 0;
        got   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (pready[k]) begin
                got = 1'b1;
                break;
            end
            check({name, " pslverr_low_while_waiting"}, 64'(pslverr[k]), 64'(0));
            waits++;
            @(posedge pclk); #1;
        end
        check({name, " pready_seen"}, 64'(got), 64'(1));
        e = exp_q.pop_front();
        if (got) begin
            check({name, " wait_cycles"}, 64'(waits), 64'(exp_waits));
            check({name, " pslverr"}, 64'(pslverr[k]), 64'(e[32]));
            if (e[33]) check({name, " prdata"}, 64'(prdata[k]), 64'(e[31:0]));
        end
        @(posedge pclk); #1;
        psel[k] = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // expected values derived by hand from the behavioural description
        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 12'h024, 32'h12345678, 4'hF, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 12'h024, 32'hCAFEF00D, 4'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 12'h024, 32'h0,        4'h0, 1'b0, 32'h12345678};
        vecs[8]  = '{1'b0, 12'h400, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 12'h402, 32'h55555555, 4'hF, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 12'h012, 32'h00000000, 4'hF, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 12'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 12'h3FC, 32'hFFFF0000, 4'hF, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 1'b0, 32'hFFFF0000};
        vecs[14] = '{1'b0, 12'h3FE, 32'h0,        4'h0, 1'b1, 32'h0};

        rst = 1'b1;
        penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        for (int k = 0; k < 3; k++) psel[k] = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);

        // reset state
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d prdata", k), 64'(prdata[k]), 64'(0));
            check($sformatf("reset%0d pready", k), 64'(pready[k]), 64'(0));
            check($sformatf("reset%0d pslverr", k), 64'(pslverr[k]), 64'(0));
            check($sformatf("reset%0d proto_err", k), 64'(proto_err[k]), 64'(0));
            check($sformatf("reset%0d state", k), 64'(st[k]), 64'(IDLE));
        end

        // zero-wait table: data path, strobes, decode errors, last word
        for (int i = 0; i < 15; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].err, vecs[i].rdata, 0, $sformatf("vec%0d", i));
        end
        check("dut0 proto_err after clean transfers", 64'(proto_err[0]), 64'(0));

        // three wait states
        xfer(1, 1'b1, 12'h000, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 3, "ws3 write");
        xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 3, "ws3 read");
        @(negedge pclk);
        check("ws3 prdata held", 64'(prdata[1]), 64'(32'hA5A5A5A5));
        check("ws3 pready dropped", 64'(pready[1]), 64'(0));
        xfer(1, 1'b1, 12'h004, 32'h01010101, 4'hF, 1'b0, 32'h0, 3, "ws3 write2");
        @(negedge pclk);
        check("ws3 prdata held over write", 64'(prdata[1]), 64'(32'hA5A5A5A5));

        // two wait states, penable dropped during WAIT
        xfer(2, 1'b1, 12'h030, 32'h01020304, 4'hF, 1'b0, 32'h0, 2, "ws2 write");
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h030; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort wait1 pready", 64'(pready[2]), 64'(0));
        check("abort wait1 proto_err", 64'(proto_err[2]), 64'(0));
        @(posedge pclk); #1;
        penable = 1'b0;
        @(negedge pclk);
        check("abort wait2 pready", 64'(pready[2]), 64'(0));
        @(posedge pclk); #1;
        psel[2] = 1'b0;
        @(negedge pclk);
        check("abort proto_err set", 64'(proto_err[2]), 64'(1));
        check("abort state idle", 64'(st[2]), 64'(IDLE));
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("abort proto_err sticky", 64'(proto_err[2]), 64'(1));
        xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, 1'b0, 32'h01020304, 2, "abort readback");
        check("abort proto_err still set", 64'(proto_err[2]), 64'(1));

        // reset during READY of a write
        xfer(0, 1'b1, 12'h040, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 0, "rst write");
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 0, "rst read");
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h040; pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("rst in ready", 64'(pready[0]), 64'(1));
        rst = 1'b1;
        #1;
        check("rst pready", 64'(pready[0]), 64'(0));
        check("rst pslverr", 64'(pslverr[0]), 64'(0));
        check("rst prdata", 64'(prdata[0]), 64'(0));
        check("rst state", 64'(st[0]), 64'(IDLE));
        check("rst proto_err cleared", 64'(proto_err[2]), 64'(0));
        @(posedge pclk); #1;
        psel[0] = 1'b0; penable = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 0, "rst readback");
        check("rst proto_err dut0", 64'(proto_err[0]), 64'(0));
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
